// File: rtl/instr_loader.sv
// Program loader: packs a big-endian UART byte stream into 32-bit words, writes them
// to instruction memory, holds the core until loading completes, then sends one ack byte.
module instr_loader #(
    parameter int unsigned DEPTH    = 32768,
    parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        reload,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        core_hold,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {S_LEN, S_DATA, S_ACK, S_DONE} state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] sr;
    logic [31:0] n_words;
    logic [31:0] word_idx;

    logic [31:0] word;
    logic        accepting;
    logic        last_byte;

    // Bytes only matter while loading; in S_ACK/S_DONE they are dropped on the floor.
    assign word      = {sr, rx_data};
    assign accepting = rx_valid && (state == S_LEN || state == S_DATA);
    assign last_byte = accepting && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LEN;
            byte_cnt  <= 2'd0;
            sr        <= '0;
            n_words   <= '0;
            word_idx  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= ACK_BYTE;
            core_hold <= 1'b1;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accepting) begin
                sr       <= word[23:0];
                byte_cnt <= byte_cnt + 2'd1;
            end
            case (state)
                S_LEN: begin
                    if (last_byte) begin
                        n_words  <= word;
                        overflow <= (word > DEPTH);
                        word_idx <= '0;
                        if (word == '0) begin
                            state    <= S_ACK;
                            tx_valid <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (last_byte) begin
                        // Words past DEPTH still advance the index so framing holds.
                        mem_we    <= (word_idx < DEPTH);
                        mem_wdata <= word;
                        mem_addr  <= {word_idx[29:0], 2'b00};
                        word_idx  <= word_idx + 32'd1;
                        if (word_idx == n_words - 32'd1) begin
                            state    <= S_ACK;
                            tx_valid <= 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    if (tx_valid && tx_ready) begin
                        state     <= S_DONE;
                        tx_valid  <= 1'b0;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (reload) begin
                        state     <= S_LEN;
                        core_hold <= 1'b1;
                        done      <= 1'b0;
                        byte_cnt  <= 2'd0;
                        word_idx  <= '0;
                        overflow  <= 1'b0;
                    end
                end
                default: state <= S_LEN;
            endcase
        end
    end

endmodule
